warp_issue_sched: RTL and testbench
===================================

// Module: warp_issue_sched
// PURPOSE
//  Per-SM warp scheduler. Picks one eligible warp per cycle round-robin and hands its ID
//  to the issue stage over a registered valid/ready slot.
//  Tracks per-warp lifecycle (idle/run/barrier) and in-flight instruction credits.
//  Sits between warp launch/scoreboard logic and the decode/issue pipeline.
// PARAMETERS
//  NUM_WARPS  8                          warps per SM; power of 2, >=2
//  CREDITS    4                          max in-flight instructions per warp, >=1
//  WID_W      $clog2(NUM_WARPS)          warp ID width (derived)
//  CRD_W      $clog2(CREDITS+1)          credit counter width (derived)
// PORTS
//  clk              in   1          system clock
//  rst              in   1          synchronous, active-high reset
//  launch_i         in   NUM_WARPS  1-cycle pulse per warp: IDLE->RUN
//  exit_valid_i     in   1          warp exit event
//  exit_wid_i       in   WID_W      exiting warp ID
//  bar_valid_i      in   1          warp reached barrier
//  bar_wid_i        in   WID_W      arriving warp ID
//  crd_ret_valid_i  in   1          one instruction of a warp retired
//  crd_ret_wid_i    in   WID_W      retiring warp ID
//  stall_i          in   NUM_WARPS  scoreboard hazard, level; 1 = not eligible
//  issue_valid_o    out  1          issue slot holds a warp
//  issue_wid_o      out  WID_W      warp ID in issue slot
//  issue_ready_i    in   1          issue stage accepts slot this cycle
//  active_o         out  NUM_WARPS  warp state != IDLE
//  all_idle_o       out  1          every warp IDLE and slot empty
// BEHAVIOUR
//  Reset: all warps IDLE, credits=CREDITS, RR pointer=warp 0, issue_valid_o=0,
//    issue_wid_o=0, active_o=0, all_idle_o=1.
//  Per-warp FSM: IDLE -launch-> RUN (credits reloaded to CREDITS); RUN -bar-> BAR;
//    RUN/BAR -exit-> IDLE; BAR -release-> RUN. Launch on non-IDLE, bar on non-RUN,
//    exit on IDLE: ignored. Exit beats bar for the same warp in the same cycle.
//  Barrier release: when >=1 warp is BAR and every non-IDLE warp is BAR (using
//    post-update states), all BAR warps go RUN on the next edge. An exit that
//    completes the condition triggers release one cycle later.
//  Eligible(w) = RUN & ~stall_i[w] & credits[w]!=0.
//  Slot load: when the slot is free (!issue_valid_o) or the slot is accepted this
//    cycle (issue_valid_o & issue_ready_i), grant the first eligible warp at or after
//    the RR pointer. The grant loads the slot, decrements credits of the granted warp
//    and sets the pointer to grant+1 (mod NUM_WARPS). No eligible warp: slot goes or
//    stays empty, and pointer is unchanged.
//  Slot hold: while issue_valid_o & !issue_ready_i, issue_wid_o is stable and no grant
//    occurs. This holds even if the held warp stalls, exits or hits a barrier: the
//    slot is never retracted.
//  Latency: launch pulse in cycle N -> RUN in N+1 -> issue_valid_o at N+2 if eligible.
//    Sustained throughput is 1 issue/cycle with issue_ready_i=1.
//  Credits: grant -1 and return +1 in the same cycle for the same warp -> unchanged.
//    A return at CREDITS saturates; the return is ignored (assertion fires in sim).
//    A return for an IDLE warp is ignored.
//  Reset mid-operation: rst asserted in any cycle forces the full reset state on the
//    next edge. A held slot is dropped.
// STRUCTURE
//  Shared package: typedef enum logic[1:0] {W_IDLE,W_RUN,W_BAR} warp_state_e;
//    warp ID / credit widths as localparam-derived typedefs.
//  Sub-module: fixed_pri_arb_base (existing; req, one-hot pri, grant), driven with a
//    one-hot priority derived from the RR pointer.
//  In this block: per-warp FSM and credits, barrier release, slot register, pointer.
// TESTING
//  1 Reset, launch_i=8'hFF, stall_i=0, ready=1 -> issue_wid_o 0,1,..,7,0 from cycle 2,
//    one per cycle.
//  2 CREDITS=4, warp 3 only, no returns -> exactly 4 issues of wid 3, then
//    issue_valid_o=0. One crd_ret -> exactly one more issue.
//  3 Slot wid 5 held, ready=0 for 6 cycles while stall_i[5]=1 -> wid 5 stable, no
//    credit change. ready=1 -> next eligible warp after 5.
//  4 Warps 0-3 active; bar on 0,1,2; exit 3 -> cycle after exit all BAR, next cycle
//    0-2 RUN, issues resume from pointer.
//  5 Same-cycle grant and crd_ret on warp 2 with credits=1 -> credits stay 1.
//    crd_ret at 4 -> stays 4, assertion fires.
//  6 rst pulse while slot valid, with warps in BAR -> next cycle issue_valid_o=0,
//    active_o=0, all_idle_o=1, pointer=0.

Source files
------------

// File: rtl/warp_issue_sched_pkg.sv
// Shared types for the warp issue scheduler: per-warp lifecycle states and
// default-geometry ID / credit types.
package warp_issue_sched_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_RUN  = 2'd1,
      W_BAR  = 2'd2
   } warp_state_e;

   localparam int unsigned DEF_NUM_WARPS = 8;
   localparam int unsigned DEF_CREDITS   = 4;
   localparam int unsigned DEF_WID_W     = $clog2(DEF_NUM_WARPS);
   localparam int unsigned DEF_CRD_W     = $clog2(DEF_CREDITS + 1);

   typedef logic [DEF_WID_W-1:0] wid_t;
   typedef logic [DEF_CRD_W-1:0] crd_t;

endpackage

// File: rtl/warp_issue_sched_arb.sv
// Fixed-priority arbiter with a rotating start point: grants the first
// requester at or after the one-hot priority position, wrapping around.
module fixed_pri_arb_base #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] pri,
   output logic [N-1:0] grant
);

   logic [2*N-1:0] dreq;
   logic [2*N-1:0] dgrant;

   // Borrow ripples up from the priority bit to the first set request,
   // which is the only request bit cleared by the subtraction.
   assign dreq   = {req, req};
   assign dgrant = dreq & ~(dreq - {{N{1'b0}}, pri});
   assign grant  = dgrant[N-1:0] | dgrant[2*N-1:N];

endmodule

// File: rtl/warp_issue_sched.sv
// Per-SM warp scheduler: round-robin pick of one eligible warp per cycle into
// a registered valid/ready issue slot, with per-warp lifecycle and credits.
module warp_issue_sched
   import warp_issue_sched_pkg::*;
#(
   parameter int unsigned NUM_WARPS = 8,
   parameter int unsigned CREDITS   = 4,
   localparam int unsigned WID_W    = $clog2(NUM_WARPS),
   localparam int unsigned CRD_W    = $clog2(CREDITS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_WARPS-1:0] launch_i,
   input  logic                 exit_valid_i,
   input  logic [WID_W-1:0]     exit_wid_i,
   input  logic                 bar_valid_i,
   input  logic [WID_W-1:0]     bar_wid_i,
   input  logic                 crd_ret_valid_i,
   input  logic [WID_W-1:0]     crd_ret_wid_i,
   input  logic [NUM_WARPS-1:0] stall_i,
   output logic                 issue_valid_o,
   output logic [WID_W-1:0]     issue_wid_o,
   input  logic                 issue_ready_i,
   output logic [NUM_WARPS-1:0] active_o,
   output logic                 all_idle_o
);

   localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CREDITS);

   warp_state_e          state_q [NUM_WARPS];
   warp_state_e          state_d [NUM_WARPS];
   logic [CRD_W-1:0]     crd_q   [NUM_WARPS];
   logic [CRD_W-1:0]     crd_d   [NUM_WARPS];
   logic [WID_W-1:0]     ptr_q;
   logic                 slot_valid_q;
   logic [WID_W-1:0]     slot_wid_q;

   logic [NUM_WARPS-1:0] is_run, is_bar, elig, req, pri, grant;
   logic [NUM_WARPS-1:0] exit_hit, bar_hit, ret_hit;
   logic [WID_W-1:0]     grant_wid;
   logic                 load, release_bar;

   always_comb begin
      is_run = '0;
      is_bar = '0;
      elig   = '0;
      pri    = '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         is_run[w] = (state_q[w] == W_RUN);
         is_bar[w] = (state_q[w] == W_BAR);
         elig[w]   = is_run[w] & ~stall_i[w] & (crd_q[w] != '0);
      end
      pri[ptr_q]  = 1'b1;
      release_bar = (|is_bar) & ~(|is_run);
      load        = ~slot_valid_q | issue_ready_i;
      req         = load ? elig : '0;
   end

   fixed_pri_arb_base #(.N(NUM_WARPS)) u_arb (
      .req   (req),
      .pri   (pri),
      .grant (grant)
   );

   always_comb begin
      grant_wid = '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         if (grant[w]) grant_wid = WID_W'(w);
      end
   end

   assign exit_hit = exit_valid_i    ? (NUM_WARPS'(1) << exit_wid_i)    : '0;
   assign bar_hit  = bar_valid_i     ? (NUM_WARPS'(1) << bar_wid_i)     : '0;
   assign ret_hit  = crd_ret_valid_i ? (NUM_WARPS'(1) << crd_ret_wid_i) : '0;

   always_comb begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         state_d[w] = state_q[w];
         crd_d[w]   = crd_q[w];
         unique case (state_q[w])
            W_IDLE: if (launch_i[w]) state_d[w] = W_RUN;
            W_RUN: begin
               if (exit_hit[w])     state_d[w] = W_IDLE;
               else if (bar_hit[w]) state_d[w] = W_BAR;
            end
            W_BAR: begin
               if (exit_hit[w])      state_d[w] = W_IDLE;
               else if (release_bar) state_d[w] = W_RUN;
            end
            default: state_d[w] = W_IDLE;
         endcase
         // A return at full count only counts when a grant consumes a credit in the same cycle.
         if (state_q[w] == W_IDLE) begin
            if (launch_i[w]) crd_d[w] = CRD_FULL;
         end else begin
            crd_d[w] = crd_q[w] - CRD_W'(grant[w])
                     + CRD_W'(ret_hit[w] & ((crd_q[w] != CRD_FULL) | grant[w]));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            state_q[w] <= W_IDLE;
            crd_q[w]   <= CRD_FULL;
         end
         ptr_q        <= '0;
         slot_valid_q <= 1'b0;
         slot_wid_q   <= '0;
      end else begin
         for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            state_q[w] <= state_d[w];
            crd_q[w]   <= crd_d[w];
         end
         if (load) begin
            slot_valid_q <= |grant;
            if (|grant) begin
               slot_wid_q <= grant_wid;
               ptr_q      <= grant_wid + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && crd_ret_valid_i) begin
         assert (state_q[crd_ret_wid_i] == W_IDLE || crd_q[crd_ret_wid_i] != CRD_FULL
                 || grant[crd_ret_wid_i])
         else $warning("credit return for warp %0d at full count ignored", crd_ret_wid_i);
      end
   end

   always_comb begin
      active_o = '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         active_o[w] = (state_q[w] != W_IDLE);
      end
   end

   assign issue_valid_o = slot_valid_q;
   assign issue_wid_o   = slot_wid_q;
   assign all_idle_o    = ~(|active_o) & ~slot_valid_q;

endmodule

// File: tb/tb_warp_issue_sched.sv
// Directed and randomized checks of warp_issue_sched against a behavioural
// model of warp lifecycle, credits and round-robin slot issue.
module tb_warp_issue_sched;

   localparam int N = 8;
   localparam int C = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] launch_i = '0;
   logic         exit_valid_i = 1'b0;
   logic [2:0]   exit_wid_i = '0;
   logic         bar_valid_i = 1'b0;
   logic [2:0]   bar_wid_i = '0;
   logic         crd_ret_valid_i = 1'b0;
   logic [2:0]   crd_ret_wid_i = '0;
   logic [N-1:0] stall_i = '0;
   logic         issue_valid_o;
   logic [2:0]   issue_wid_o;
   logic         issue_ready_i = 1'b1;
   logic [N-1:0] active_o;
   logic         all_idle_o;

   int checks = 0;
   int errors = 0;

   // model: 0 = idle, 1 = running, 2 = at barrier
   int ms [N];
   int mc [N];
   int mptr;
   bit mv;
   int mwid;

   warp_issue_sched #(.NUM_WARPS(N), .CREDITS(C)) dut (
      .clk(clk), .rst(rst), .launch_i(launch_i),
      .exit_valid_i(exit_valid_i), .exit_wid_i(exit_wid_i),
      .bar_valid_i(bar_valid_i), .bar_wid_i(bar_wid_i),
      .crd_ret_valid_i(crd_ret_valid_i), .crd_ret_wid_i(crd_ret_wid_i),
      .stall_i(stall_i), .issue_valid_o(issue_valid_o), .issue_wid_o(issue_wid_o),
      .issue_ready_i(issue_ready_i), .active_o(active_o), .all_idle_o(all_idle_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_update();
      int g, ns [N], nc [N];
      bit take, any_bar, any_run;
      if (rst) begin
         for (int w = 0; w < N; w++) begin ms[w] = 0; mc[w] = C; end
         mptr = 0; mv = 0; mwid = 0;
         return;
      end
      take = !mv || issue_ready_i;
      g = -1;
      if (take) begin
         for (int k = 0; k < N; k++) begin
            int w = (mptr + k) % N;
            if (ms[w] == 1 && !stall_i[w] && mc[w] > 0) begin g = w; break; end
         end
      end
      any_bar = 0; any_run = 0;
      for (int w = 0; w < N; w++) begin
         if (ms[w] == 2) any_bar = 1;
         if (ms[w] == 1) any_run = 1;
      end
      for (int w = 0; w < N; w++) begin
         ns[w] = ms[w];
         nc[w] = mc[w];
         if (ms[w] == 0) begin
            if (launch_i[w]) begin ns[w] = 1; nc[w] = C; end
         end else begin
            if (exit_valid_i && exit_wid_i == w) ns[w] = 0;
            else if (ms[w] == 1 && bar_valid_i && bar_wid_i == w) ns[w] = 2;
            else if (ms[w] == 2 && any_bar && !any_run) ns[w] = 1;
            if (g == w) nc[w]--;
            if (crd_ret_valid_i && crd_ret_wid_i == w) nc[w]++;
            if (nc[w] > C) nc[w] = C;
         end
      end
      for (int w = 0; w < N; w++) begin ms[w] = ns[w]; mc[w] = nc[w]; end
      if (take) begin
         mv = (g >= 0);
         if (g >= 0) begin mwid = g; mptr = (g + 1) % N; end
      end
   endtask

   task automatic step();
      logic [N-1:0] act;
      @(posedge clk);
      model_update();
      #1;
      act = '0;
      for (int w = 0; w < N; w++) act[w] = (ms[w] != 0);
      chk("valid", issue_valid_o, mv);
      if (mv) chk("wid", issue_wid_o, mwid);
      chk("active", active_o, act);
      chk("all_idle", all_idle_o, (act == 0) && !mv);
      launch_i = '0; exit_valid_i = 0; bar_valid_i = 0; crd_ret_valid_i = 0;
   endtask

   task automatic do_reset();
      rst = 1; step(); rst = 0;
   endtask

   initial begin
      int n;
      // reset state
      do_reset();
      chk("rst_valid", issue_valid_o, 0);
      chk("rst_wid", issue_wid_o, 0);
      chk("rst_active", active_o, 0);
      chk("rst_idle", all_idle_o, 1);

      // round-robin over all warps, one issue per cycle
      launch_i = 8'hFF; issue_ready_i = 1; step();
      chk("t1_latency", issue_valid_o, 0);
      for (int k = 0; k < 9; k++) begin
         step();
         chk("t1_valid", issue_valid_o, 1);
         chk("t1_wid", issue_wid_o, k % 8);
      end

      // credit exhaustion then a single return
      do_reset();
      launch_i = 8'h08; step();
      n = 0;
      for (int k = 0; k < 10; k++) begin step(); if (issue_valid_o && issue_wid_o == 3) n++; end
      chk("t2_issues", n, 4);
      chk("t2_empty", issue_valid_o, 0);
      crd_ret_valid_i = 1; crd_ret_wid_i = 3;
      n = 0;
      for (int k = 0; k < 7; k++) begin step(); if (issue_valid_o) n++; end
      chk("t2_extra", n, 1);

      // held slot survives a stall of the held warp
      do_reset();
      launch_i = 8'h60; issue_ready_i = 0; step(); step();
      chk("t3_load", issue_wid_o, 5);
      stall_i = 8'h20;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("t3_hold_v", issue_valid_o, 1);
         chk("t3_hold_w", issue_wid_o, 5);
      end
      issue_ready_i = 1; step();
      chk("t3_next", issue_wid_o, 6);
      stall_i = '0;

      // barrier completed by an exit
      do_reset();
      launch_i = 8'h0F; step(); step(); step();
      bar_valid_i = 1; bar_wid_i = 0; step();
      bar_valid_i = 1; bar_wid_i = 1; step();
      bar_valid_i = 1; bar_wid_i = 2; step();
      exit_valid_i = 1; exit_wid_i = 3; step();
      chk("t4_allbar", active_o, 8'h07);
      step();
      chk("t4_quiet", issue_valid_o, 0);
      step();
      chk("t4_resume", issue_valid_o, 1);

      // grant and return on the same cycle, then saturation
      do_reset();
      launch_i = 8'h04; step();
      n = 0;
      for (int k = 0; k < 3; k++) begin step(); if (issue_valid_o) n++; end
      crd_ret_valid_i = 1; crd_ret_wid_i = 2; step(); if (issue_valid_o) n++;
      for (int k = 0; k < 6; k++) begin step(); if (issue_valid_o) n++; end
      chk("t5_issues", n, 5);
      stall_i = 8'h04;
      for (int k = 0; k < 5; k++) begin crd_ret_valid_i = 1; crd_ret_wid_i = 2; step(); end
      stall_i = '0;
      n = 0;
      for (int k = 0; k < 8; k++) begin step(); if (issue_valid_o) n++; end
      chk("t5_saturate", n, 4);

      // reset while slot held and a warp at barrier
      do_reset();
      launch_i = 8'h03; issue_ready_i = 0; step(); step();
      bar_valid_i = 1; bar_wid_i = 1; step();
      rst = 1; step(); rst = 0;
      chk("t6_valid", issue_valid_o, 0);
      chk("t6_active", active_o, 0);
      chk("t6_idle", all_idle_o, 1);
      launch_i = 8'h81; issue_ready_i = 1; step(); step();
      chk("t6_ptr", issue_wid_o, 0);

      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         int w;
         rst = ($urandom_range(0, 299) == 0);
         launch_i = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         exit_valid_i = ($urandom_range(0, 9) == 0); exit_wid_i = 3'($urandom);
         bar_valid_i = ($urandom_range(0, 5) == 0); bar_wid_i = 3'($urandom);
         w = $urandom_range(0, N - 1);
         crd_ret_valid_i = ($urandom_range(0, 1) == 1) && mc[w] < C;
         crd_ret_wid_i = 3'(w);
         stall_i = N'($urandom & $urandom);
         issue_ready_i = ($urandom_range(0, 3) != 0);
         step();
      end
      rst = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
